// File: rtl/sha_padder.sv
// sha_padder: byte-serial SHA-256 message padder feeding 512-bit blocks to a SHA core.
// Optional sticky overrun flag o_fOverrun when SHA_PAD_OVERRUN_EN is defined.
module sha_padder (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [7:0]   i_Byte,
  input  logic         i_fValid,
  input  logic         i_fLast,
  output logic         o_fReady,
  output logic [511:0] o_Block,
  output logic         o_fStart,
  output logic         o_fFirst,
  input  logic         i_fDone,
  output logic         o_fMsgDone
`ifdef SHA_PAD_OVERRUN_EN
  ,
  output logic         o_fOverrun
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, PAD, PAD2, SEND, WAIT} state_t;
  state_t state_q, state_d;
  logic [511:0] blk_q, blk_d;
  logic [6:0] pos_q, pos_d;
  logic [63:0] len_q, len_d;
  logic first_q, first_d, fin_q, fin_d, pend_q, pend_d, done_q, done_d;
  logic acc;
  assign o_fReady = (state_q == IDLE) || (state_q == LOAD);
  assign acc = i_fValid && o_fReady;
  assign o_Block = blk_q;
  assign o_fStart = state_q == SEND;
  assign o_fFirst = (state_q == SEND) && first_q;
  assign o_fMsgDone = done_q;
  // Bytes past pos are always zero, so padding only has to place 0x80 and the length.
  always_comb begin
    state_d = state_q;
    blk_d = blk_q;
    pos_d = pos_q;
    len_d = len_q;
    first_d = first_q;
    fin_d = fin_q;
    pend_d = pend_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      blk_d = '0;
      pos_d = '0;
      len_d = '0;
      first_d = 1'b1;
      fin_d = 1'b0;
      pend_d = 1'b0;
    end
    if (acc) begin
      blk_d[9'd511 - {pos_d[5:0], 3'b000} -: 8] = i_Byte;
      pos_d = pos_d + 7'd1;
      len_d = len_d + 64'd8;
      state_d = i_fLast ? PAD : (pos_d == 7'd64 ? SEND : LOAD);
    end
    case (state_q)
      PAD: begin
        if (pos_q < 7'd64) blk_d[9'd511 - {pos_q[5:0], 3'b000} -: 8] = 8'h80;
        if (pos_q <= 7'd55) begin
          blk_d[63:0] = len_q;
          fin_d = 1'b1;
        end else pend_d = 1'b1;
        state_d = SEND;
      end
      PAD2: begin
        blk_d = {pos_q == 7'd64 ? 8'h80 : 8'h00, 440'd0, len_q};
        fin_d = 1'b1;
        pend_d = 1'b0;
        state_d = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (i_fDone) begin
          first_d = 1'b0;
          done_d = fin_q;
          state_d = fin_q ? IDLE : (pend_q ? PAD2 : LOAD);
          if (!fin_q && !pend_q) begin
            blk_d = '0;
            pos_d = '0;
          end
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      blk_q <= '0;
      pos_q <= '0;
      len_q <= '0;
      first_q <= 1'b1;
      fin_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q <= blk_d;
      pos_q <= pos_d;
      len_q <= len_d;
      first_q <= first_d;
      fin_q <= fin_d;
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end
`ifdef SHA_PAD_OVERRUN_EN
  logic ovr_q;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) ovr_q <= 1'b0;
    else if (state_q == IDLE && acc) ovr_q <= 1'b0;
    else if (i_fValid && !o_fReady) ovr_q <= 1'b1;
  end
  assign o_fOverrun = ovr_q;
`endif
endmodule

// File: tb/tb_sha_padder.sv
// tb_sha_padder: directed self-checking bench for sha_padder.
module tb_sha_padder;
  logic Clk = 1'b0, Rst = 1'b0;
  logic [7:0] i_Byte = '0;
  logic i_fValid = 1'b0, i_fLast = 1'b0, i_fDone = 1'b0;
  logic o_fReady, o_fStart, o_fFirst, o_fMsgDone;
  logic [511:0] o_Block;
`ifdef SHA_PAD_OVERRUN_EN
  logic o_fOverrun;
`endif
  int ncmp = 0, nerr = 0;
  logic [7:0] msg[$];
  logic [447:0] s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  localparam logic [511:0] E_ABC = {32'h61626380, 416'd0, 64'h18};

  sha_padder dut (
    .Clk(Clk), .Rst(Rst), .i_Byte(i_Byte), .i_fValid(i_fValid), .i_fLast(i_fLast),
    .o_fReady(o_fReady), .o_Block(o_Block), .o_fStart(o_fStart), .o_fFirst(o_fFirst),
    .i_fDone(i_fDone), .o_fMsgDone(o_fMsgDone)
`ifdef SHA_PAD_OVERRUN_EN
    , .o_fOverrun(o_fOverrun)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk1(input string tag, input logic o, input logic e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chkb(input string tag, input logic [511:0] o, input logic [511:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic send_msg(input bit last);
    foreach (msg[i]) begin
      i_Byte = msg[i];
      i_fValid = 1'b1;
      i_fLast = last && (i == msg.size() - 1);
      @(negedge Clk);
    end
    i_fValid = 1'b0;
    i_fLast = 1'b0;
  endtask

  task automatic blk(input string tag, input logic [511:0] e, input bit first, input bit fin,
                     input int lat, input bit spam);
    int c = 0;
    while (!o_fStart && c < 8) begin
      @(negedge Clk);
      c++;
    end
    chk1({tag, "_start"}, o_fStart, 1'b1);
    chk1({tag, "_latency"}, c == lat, 1'b1);
    chk1({tag, "_first"}, o_fFirst, first);
    chkb({tag, "_block"}, o_Block, e);
    if (spam) begin
      i_fValid = 1'b1;
      i_Byte = 8'hff;
      i_fDone = 1'b1;
    end
    @(negedge Clk);
    chk1({tag, "_pulse1"}, o_fStart, 1'b0);
    chkb({tag, "_hold"}, o_Block, e);
    if (spam) begin
      i_fDone = 1'b0;
      @(negedge Clk);
      chkb({tag, "_nocapture"}, o_Block, e);
      chk1({tag, "_busy"}, o_fReady, 1'b0);
      chk1({tag, "_donesend_ignored"}, o_fMsgDone, 1'b0);
`ifdef SHA_PAD_OVERRUN_EN
      chk1({tag, "_overrun"}, o_fOverrun, 1'b1);
`endif
      i_fValid = 1'b0;
    end
    i_fDone = 1'b1;
    @(negedge Clk);
    i_fDone = 1'b0;
    chk1({tag, "_msgdone"}, o_fMsgDone, fin);
    if (fin) chk1({tag, "_idle_ready"}, o_fReady, 1'b1);
  endtask

  task automatic abc(input string tag);
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(1);
    chk1({tag, "_pad_nostart"}, o_fStart, 1'b0);
    blk(tag, E_ABC, 1, 1, 1, 0);
    @(negedge Clk);
    chk1({tag, "_msgdone_pulse"}, o_fMsgDone, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chkb("rst_block", o_Block, '0);
    chk1("rst_start", o_fStart, 1'b0);
    chk1("rst_msgdone", o_fMsgDone, 1'b0);
    Rst = 1'b1;
    @(negedge Clk);
    chk1("rst_ready", o_fReady, 1'b1);

    abc("abc");

    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(s[447 - 8*i -: 8]);
    send_msg(1);
    blk("m56_b1", {s, 8'h80, 56'd0}, 1, 0, 1, 0);
    blk("m56_b2", {448'd0, 64'h1c0}, 0, 1, 1, 0);

    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'h00);
    send_msg(1);
    blk("z64_b1", '0, 1, 0, 1, 0);
    blk("z64_b2", {8'h80, 440'd0, 64'h200}, 0, 1, 1, 0);

    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'h11);
    send_msg(0);
    blk("m65_b1", {64{8'h11}}, 1, 0, 0, 1);
    chk1("m65_reload_ready", o_fReady, 1'b1);
    msg = '{8'h22};
    send_msg(1);
    blk("m65_b2", {16'h2280, 432'd0, 64'h208}, 0, 1, 1, 0);

    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(1);
    repeat (2) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    chkb("rstw_block", o_Block, '0);
    chk1("rstw_start", o_fStart, 1'b0);
    chk1("rstw_first", o_fFirst, 1'b0);
    chk1("rstw_msgdone", o_fMsgDone, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk1("rstw_ready", o_fReady, 1'b1);
    abc("abc2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
